// File: rtl/cfg_ctrl_pkg.sv
// rtl/cfg_ctrl_pkg.sv - shared types and helpers for the configuration chain controller
//
// Contents:
//   cfg_state_t   - sequencer states
//   words_per_op  - number of WORD_W-bit words needed to cover a chain of chain_len bits
package cfg_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_LOAD     = 3'd4,
        ST_FINISH   = 3'd5
    } cfg_state_t;

    function automatic int words_per_op(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous input bit
//
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset, both flops clear to 0
//   d    - asynchronous input
//   q    - synchronized output, two clk cycles of latency
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/config_chain_ctrl.sv
// rtl/config_chain_ctrl.sv - sequencer that shifts the DUT configuration chain and captures readback
//
// Ports:
//   pl_clk1, reset          - block clock, asynchronous active-high reset
//   start, abort            - operation request (IDLE only) and synchronous abort
//   clk_div, load_en        - half-period H and latch-strobe enable, both sampled at start
//   wr_data/valid/ready     - config words in, LSB shifted first
//   rd_data/valid/ready     - captured readback words out
//   busy, done, aborted     - status: not IDLE, normal completion pulse, abort pulse
//   config_clk/in/load      - chain pins driven to the DUT
//   config_out              - asynchronous serial readback from the DUT
module config_chain_ctrl
    import cfg_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 768,
    parameter int WORD_W    = 32,
    parameter int DIV_W     = 8
) (
    input  logic              pl_clk1,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              load_en,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              config_clk,
    output logic              config_in,
    output logic              config_load,
    input  logic              config_out
);

    localparam int NUM_WORDS      = words_per_op(CHAIN_LEN, WORD_W);
    localparam int LAST_WORD_BITS = CHAIN_LEN - (NUM_WORDS - 1) * WORD_W;
    localparam int BC_W           = $clog2(CHAIN_LEN + 1);
    localparam int WB_W           = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int WI_W           = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int PH_W           = DIV_W + 1;

    localparam logic [BC_W-1:0] LAST_BIT      = BC_W'(CHAIN_LEN - 1);
    localparam logic [WI_W-1:0] LAST_WORD     = WI_W'(NUM_WORDS - 1);
    localparam logic [WB_W-1:0] FULL_WORD_END = WB_W'(WORD_W - 1);
    localparam logic [WB_W-1:0] PART_WORD_END = WB_W'(LAST_WORD_BITS - 1);

    cfg_state_t        state;
    logic [DIV_W-1:0]  h_q;
    logic              load_en_q;
    logic [PH_W-1:0]   phase_cnt;
    logic [BC_W-1:0]   bit_cnt;
    logic [WB_W-1:0]   word_bit;
    logic [WI_W-1:0]   word_idx;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] cap;
    logic              cfg_out_sync;

    logic              shift_phase_end;
    logic              load_phase_end;
    logic [WB_W-1:0]   word_end_bit;
    logic              word_end;
    logic [WORD_W-1:0] cap_next;

    sync_2ff u_sync_cfg_out (
        .clk (pl_clk1),
        .rst (reset),
        .d   (config_out),
        .q   (cfg_out_sync)
    );

    // Shift phases last H cycles, the load strobe lasts 2H cycles.
    assign shift_phase_end = (phase_cnt == ({1'b0, h_q} - 1'b1));
    assign load_phase_end  = (phase_cnt == ({h_q, 1'b0} - 1'b1));

    // The last word of an operation may be partial; its final bit index is shorter.
    assign word_end_bit = (word_idx == LAST_WORD) ? PART_WORD_END : FULL_WORD_END;
    assign word_end     = (word_bit == word_end_bit);
    assign cap_next     = cap | (WORD_W'(cfg_out_sync) << word_bit);

    // Pins and handshakes decode straight from registered state, so reset clears them
    // asynchronously and wr_ready has no path from wr_valid.
    assign busy        = (state != ST_IDLE);
    assign wr_ready    = (state == ST_FETCH) && !rd_valid;
    assign config_clk  = (state == ST_SHIFT_HI);
    assign config_in   = ((state == ST_SHIFT_LO) || (state == ST_SHIFT_HI)) && shreg[0];
    assign config_load = (state == ST_LOAD);

    always_ff @(posedge pl_clk1 or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            h_q       <= '0;
            load_en_q <= 1'b0;
            phase_cnt <= '0;
            bit_cnt   <= '0;
            word_bit  <= '0;
            word_idx  <= '0;
            shreg     <= '0;
            cap       <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;

            if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
            end

            if (abort && (state != ST_IDLE)) begin
                state     <= ST_IDLE;
                aborted   <= 1'b1;
                rd_valid  <= 1'b0;
                phase_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        // abort in IDLE blocks a simultaneous start
                        if (start && !abort) begin
                            h_q       <= (clk_div == '0) ? DIV_W'(1) : clk_div;
                            load_en_q <= load_en;
                            bit_cnt   <= '0;
                            word_idx  <= '0;
                            phase_cnt <= '0;
                            state     <= ST_FETCH;
                        end
                    end

                    ST_FETCH: begin
                        if (wr_valid && wr_ready) begin
                            shreg     <= wr_data;
                            cap       <= '0;
                            word_bit  <= '0;
                            phase_cnt <= '0;
                            state     <= ST_SHIFT_LO;
                        end
                    end

                    ST_SHIFT_LO: begin
                        if (shift_phase_end) begin
                            // Capture just before the rising edge: config_out still
                            // shows the bit that this edge will shift out.
                            phase_cnt <= '0;
                            state     <= ST_SHIFT_HI;
                            if (word_end) begin
                                rd_data  <= cap_next;
                                rd_valid <= 1'b1;
                                cap      <= '0;
                            end else begin
                                cap <= cap_next;
                            end
                        end else begin
                            phase_cnt <= phase_cnt + 1'b1;
                        end
                    end

                    ST_SHIFT_HI: begin
                        if (shift_phase_end) begin
                            phase_cnt <= '0;
                            bit_cnt   <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT) begin
                                state <= load_en_q ? ST_LOAD : ST_FINISH;
                            end else if (word_end) begin
                                word_idx <= word_idx + 1'b1;
                                state    <= ST_FETCH;
                            end else begin
                                shreg    <= shreg >> 1;
                                word_bit <= word_bit + 1'b1;
                                state    <= ST_SHIFT_LO;
                            end
                        end else begin
                            phase_cnt <= phase_cnt + 1'b1;
                        end
                    end

                    ST_LOAD: begin
                        if (load_phase_end) begin
                            phase_cnt <= '0;
                            state     <= ST_FINISH;
                        end else begin
                            phase_cnt <= phase_cnt + 1'b1;
                        end
                    end

                    ST_FINISH: begin
                        // done only once the last readback word has left
                        if (!rd_valid) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_config_chain_ctrl.sv
// tb/tb_config_chain_ctrl.sv - self-checking bench for config_chain_ctrl
module tb_config_chain_ctrl;

    localparam int CL   = 40;
    localparam int WW   = 32;
    localparam int DW   = 8;
    localparam int NUMW = (CL + WW - 1) / WW;

    logic          pl_clk1 = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [DW-1:0] clk_div;
    logic          load_en;
    logic [WW-1:0] wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [WW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic          busy;
    logic          done;
    logic          aborted;
    logic          config_clk;
    logic          config_in;
    logic          config_load;
    logic          config_out;

    // Behavioural model of the DUT configuration chain: shifts right on every
    // config_clk rise, new bit enters at the top, config_out is bit 0.
    logic [CL-1:0] chain;
    assign config_out = chain[0];

    int errors = 0;
    int checks = 0;

    bit            exp_bits[$];
    logic [WW-1:0] exp_rb[$];
    logic [WW-1:0] wq[$];
    logic [WW-1:0] rb_got[$];

    int cyc, edge_cnt, last_edge, load_len, last_load_len, load_runs;
    int done_cnt, abort_cnt, h_cur, words_sent, stall_left, rd_hold_left;
    bit prev_cclk, prev_load, load_full_exp, ld_cur, rb_check;

    config_chain_ctrl #(.CHAIN_LEN(CL), .WORD_W(WW), .DIV_W(DW)) dut (
        .pl_clk1     (pl_clk1),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .clk_div     (clk_div),
        .load_en     (load_en),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .config_clk  (config_clk),
        .config_in   (config_in),
        .config_load (config_load),
        .config_out  (config_out)
    );

    always #5 pl_clk1 = ~pl_clk1;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of the DUT pins against the model, sampled at negedge.
    task automatic monitor();
        bit b;
        cyc++;
        if (!busy)
            chk("idle_pins", {config_clk, config_in, config_load, wr_ready}, 4'b0000);
        chk("wr_ready_vs_rd_valid", wr_ready & rd_valid, 1'b0);
        if (wr_ready)
            chk("fetch_pins", {config_clk, config_load, busy}, 3'b001);
        if (config_clk && !prev_cclk) begin
            edge_cnt++;
            if (exp_bits.size() == 0) begin
                chk("edge_count_bound", edge_cnt, CL);
            end else begin
                b = exp_bits.pop_front();
                chk("config_in_bit", config_in, b);
            end
            if (((edge_cnt - 1) % WW) != 0)
                chk("bit_period", cyc - last_edge, 2 * h_cur);
            last_edge = cyc;
            chain = {config_in, chain[CL-1:1]};
        end
        if (config_load) begin
            chk("load_only_when_enabled", ld_cur, 1'b1);
            if (!prev_load) begin
                chk("load_start_edges", edge_cnt, CL);
                chk("load_start_gap", cyc - last_edge, h_cur);
            end
            load_len++;
        end else if (prev_load) begin
            if (load_full_exp)
                chk("load_len", load_len, 2 * h_cur);
            last_load_len = load_len;
            load_runs++;
            load_len = 0;
        end
        if (done) begin
            done_cnt++;
            chk("done_edges", edge_cnt, CL);
            chk("done_rb_drained", exp_rb.size() + int'(rd_valid), 0);
        end
        if (aborted)
            abort_cnt++;
        prev_cclk = config_clk;
        prev_load = config_load;
    endtask

    // Inputs for the coming posedge; wr_ready/rd_valid are state-based so the
    // values seen now are the ones the DUT uses at that edge.
    task automatic drive();
        bit            hold;
        logic [WW-1:0] e;
        hold = (words_sent == 1) && (stall_left > 0);
        if (wq.size() > 0 && !hold) begin
            wr_valid = 1'b1;
            wr_data  = wq[0];
        end else begin
            wr_valid = 1'b0;
        end
        if (hold && wr_ready)
            stall_left--;
        if (wr_valid && wr_ready) begin
            wq.delete(0);
            words_sent++;
        end
        if (rd_valid && rd_hold_left > 0) begin
            rd_ready = 1'b0;
            rd_hold_left--;
            if (rd_hold_left == 0)
                chk("backpressure_freeze", edge_cnt, WW);
        end else begin
            rd_ready = 1'b1;
        end
        if (rd_valid && rd_ready) begin
            rb_got.push_back(rd_data);
            if (exp_rb.size() == 0) begin
                chk("rb_count", rb_got.size(), NUMW);
            end else begin
                e = exp_rb.pop_front();
                if (rb_check)
                    chk("rd_data", rd_data, e);
            end
        end
    endtask

    task automatic run_op(input int div, input bit ld, input logic [CL-1:0] pre,
                          input int s_len, input int r_hold, input int abort_at,
                          input bit rst_in_load);
        bit            finished;
        bit            abort_sent;
        logic [WW-1:0] x;
        chain = pre;
        h_cur = (div == 0) ? 1 : div;
        ld_cur = ld;
        edge_cnt = 0; last_edge = 0; load_len = 0; last_load_len = 0; load_runs = 0;
        done_cnt = 0; abort_cnt = 0; words_sent = 0;
        stall_left = s_len; rd_hold_left = r_hold; load_full_exp = !rst_in_load;
        exp_bits.delete(); exp_rb.delete(); rb_got.delete();
        foreach (wq[i])
            for (int b = 0; b < WW; b++)
                if (exp_bits.size() < CL) exp_bits.push_back(wq[i][b]);
        for (int w = 0; w < NUMW; w++) begin
            x = '0;
            for (int b = 0; b < WW; b++)
                if (w * WW + b < CL) x[b] = pre[w * WW + b];
            exp_rb.push_back(x);
        end

        @(negedge pl_clk1); monitor();
        clk_div = DW'(div); load_en = ld; start = 1'b1;
        drive();
        @(negedge pl_clk1); monitor();
        start = 1'b0; clk_div = '0; load_en = 1'b0;
        drive();

        finished = 1'b0;
        abort_sent = 1'b0;
        for (int k = 0; k < 4000 && !finished; k++) begin
            @(negedge pl_clk1); monitor();
            if (abort_sent) begin
                chk("abort_response", {busy, config_clk, config_in, config_load, aborted, done}, 6'b000010);
                abort = 1'b0;
                @(negedge pl_clk1); monitor();
                chk("aborted_width", aborted, 1'b0);
                finished = 1'b1;
            end else if (done) begin
                @(negedge pl_clk1); monitor();
                chk("done_width", done, 1'b0);
                finished = 1'b1;
            end else if (rst_in_load && config_load && load_len == 3) begin
                @(posedge pl_clk1);
                #2 reset = 1'b1;
                #1;
                chk("reset_pins", {config_clk, config_in, config_load, wr_ready, rd_valid, busy, done, aborted}, 8'h00);
                chk("reset_rd_data", rd_data, 0);
                repeat (2) @(negedge pl_clk1);
                reset = 1'b0;
                @(negedge pl_clk1); monitor();
                finished = 1'b1;
            end else begin
                if (abort_at > 0 && edge_cnt == abort_at) begin
                    abort = 1'b1;
                    abort_sent = 1'b1;
                end
                drive();
            end
        end
        chk("op_completed", finished, 1'b1);
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        abort = 1'b0;
        wq.delete();
    endtask

    task automatic chk_rb(input logic [WW-1:0] w0, input logic [WW-1:0] w1);
        chk("rb_words_seen", rb_got.size(), 2);
        if (rb_got.size() == 2) begin
            chk("rb_word0_literal", rb_got[0], w0);
            chk("rb_word1_literal", rb_got[1], w1);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; clk_div = '0; load_en = 1'b0;
        wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b1; chain = '0;
        cyc = 0; prev_cclk = 1'b0; prev_load = 1'b0; rb_check = 1'b1; h_cur = 1; ld_cur = 1'b0;
        repeat (3) @(negedge pl_clk1);
        chk("reset_state", {config_clk, config_in, config_load, wr_ready, rd_valid, busy, done, aborted}, 8'h00);
        chk("reset_rd_data", rd_data, 0);
        reset = 1'b0;
        @(negedge pl_clk1); monitor();

        // abort in IDLE does nothing; abort beats a simultaneous start
        abort = 1'b1;
        @(negedge pl_clk1); monitor();
        chk("idle_abort_ignored", {busy, aborted}, 2'b00);
        start = 1'b1;
        @(negedge pl_clk1); monitor();
        chk("start_abort_collision", {busy, aborted}, 2'b00);
        start = 1'b0; abort = 1'b0;

        // Case 1: basic shift with readback and load pulse
        wq = '{32'hA5A5_0F0F, 32'h0000_00C3};
        run_op(3, 1'b1, 40'h12_3456_789A, 0, 0, 0, 1'b0);
        chk("c1_chain", chain, 40'hC3_A5A5_0F0F);
        chk_rb(32'h3456_789A, 32'h0000_0012);
        chk("c1_edges", edge_cnt, 40);
        chk("c1_load_runs", load_runs, 1);
        chk("c1_load_len", last_load_len, 6);
        chk("c1_done", done_cnt, 1);

        // Case 2: minimum divider, no load
        rb_check = 1'b0;
        wq = '{32'hDEAD_BEEF, 32'h0000_005A};
        run_op(0, 1'b0, 40'h00_0000_0000, 0, 0, 0, 1'b0);
        rb_check = 1'b1;
        chk("c2_chain", chain, 40'h5A_DEAD_BEEF);
        chk("c2_load_runs", load_runs, 0);
        chk("c2_done", done_cnt, 1);

        // Case 3: 20-cycle write stall before word 1
        wq = '{32'hA5A5_0F0F, 32'h0000_00C3};
        run_op(3, 1'b1, 40'h12_3456_789A, 20, 0, 0, 1'b0);
        chk("c3_stall_used", stall_left, 0);
        chk("c3_chain", chain, 40'hC3_A5A5_0F0F);
        chk_rb(32'h3456_789A, 32'h0000_0012);
        chk("c3_done", done_cnt, 1);

        // Case 4: readback backpressure after the first word
        wq = '{32'h0F1E_2D3C, 32'h0000_0077};
        run_op(4, 1'b0, 40'hFE_DCBA_9876, 0, 30, 0, 1'b0);
        chk("c4_chain", chain, 40'h77_0F1E_2D3C);
        chk_rb(32'hDCBA_9876, 32'h0000_00FE);
        chk("c4_done", done_cnt, 1);

        // Case 5: abort at bit 17, then a full run
        wq = '{32'hA5A5_0F0F, 32'h0000_00C3};
        run_op(3, 1'b1, 40'h12_3456_789A, 0, 0, 17, 1'b0);
        chk("c5_abort_edges", edge_cnt, 17);
        chk("c5_aborted", abort_cnt, 1);
        chk("c5_no_done", done_cnt, 0);
        chk("c5_no_load", load_runs, 0);
        wq = '{32'h1357_9BDF, 32'h0000_0024};
        run_op(3, 1'b1, 40'h12_3456_789A, 0, 0, 0, 1'b0);
        chk("c5_rerun_chain", chain, 40'h24_1357_9BDF);
        chk("c5_rerun_done", done_cnt, 1);

        // Case 6: async reset during the load pulse, then a normal run
        wq = '{32'hA5A5_0F0F, 32'h0000_00C3};
        run_op(3, 1'b1, 40'h12_3456_789A, 0, 0, 0, 1'b1);
        chk("c6_no_done", done_cnt, 0);
        chk("c6_short_load", last_load_len, 3);
        wq = '{32'hA5A5_0F0F, 32'h0000_00C3};
        run_op(3, 1'b1, 40'h12_3456_789A, 0, 0, 0, 1'b0);
        chk("c6_rerun_chain", chain, 40'hC3_A5A5_0F0F);
        chk("c6_rerun_done", done_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
